crosswalk_request_unit: RTL and testbench



---
 rtl/crosswalk_pkg.sv | 30 +++
 rtl/sync_debounce.sv | 99 +++++++++
 rtl/crosswalk_request_unit.sv | 108 ++++++++++
 tb/tb_crosswalk_request_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/crosswalk_pkg.sv
// Shared constants for the crosswalk request front end: debounce FSM state
// encodings, default timing values, served-counter width and small helpers.
package crosswalk_pkg;

  // Debounce FSM encodings; numeric values are shared with older tooling.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK = 2'd1;
  localparam logic [1:0] ST_PRESSED   = 2'd2;
  localparam logic [1:0] ST_REL_CHK   = 2'd3;

  // Default timing, in CLK cycles.
  localparam int DEF_DEBOUNCE_CYCLES = 20000;
  localparam int DEF_SENSOR_HOLD     = 5000;
  localparam int DEF_CNT_W           = 32;

  // Width of the served-request counter.
  localparam int SERVED_W = 8;

  // Rising-edge strobes derived from the controller lamp feedback.
  typedef struct packed {
    logic pg_rise;
    logic rg_rise;
  } fb_edge_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [SERVED_W-1:0] sat_inc(input logic [SERVED_W-1:0] v);
    return (v == '1) ? v : v + SERVED_W'(1);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a four-state debounce FSM. Emits a single
// registered press_evt pulse when a press has been stable for DEBOUNCE_CYCLES
// synchronized samples; a new press needs a debounced release first.
module sync_debounce
  import crosswalk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_raw,
  output logic o_press_evt
);

  localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       r_sync;
  logic             w_sync;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_press_evt;
  logic             w_evt_nxt;

  assign w_sync      = r_sync[1];
  assign o_press_evt = r_press_evt;

  // Bring the asynchronous raw input into the CLK domain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], i_raw};
  end

  // Next-state and stability-counter logic; the counter never passes
  // DB_TERM because reaching it always leaves the check state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_evt_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sync) begin
          w_state_nxt = ST_PRESS_CHK;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ST_PRESS_CHK: begin
        if (!w_sync) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_TERM) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
          w_evt_nxt   = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!w_sync) begin
          w_state_nxt = ST_REL_CHK;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ST_REL_CHK: begin
        if (w_sync) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_TERM) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Register FSM state, counter and the one-cycle press event.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_press_evt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_press_evt <= w_evt_nxt;
    end
  end

endmodule

// File: rtl/crosswalk_request_unit.sv
// Crosswalk request front end: debounced pedestrian request latch, qualified
// vehicle request, WAIT lamp and a saturating served-request counter. Requests
// are held as levels until the controller's lamp feedback shows service.
module crosswalk_request_unit
  import crosswalk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SENSOR_HOLD     = DEF_SENSOR_HOLD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                BTN_RAW,
  input  logic                SENSOR_RAW,
  input  logic                PG,
  input  logic                RG,
  output logic                BUTTON,
  output logic                SENSOR,
  output logic                WAIT_LAMP,
  output logic [SERVED_W-1:0] SERVED_CNT
);

  localparam logic [CNT_W-1:0] SH_TERM = CNT_W'(SENSOR_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                w_press_evt;
  logic [1:0]          r_sen_sync;
  logic                w_sen;
  logic                r_pg_q;
  logic                r_rg_q;
  fb_edge_t            w_fb;
  logic [CNT_W-1:0]    r_hold;
  logic                r_sensor;
  logic                r_button;
  logic                w_button_nxt;
  logic                r_wait;
  logic [SERVED_W-1:0] r_served;

  // Button path: synchronize, debounce, one pulse per accepted press.
  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_db (
    .CLK         (CLK),
    .RST         (RST),
    .i_raw       (BTN_RAW),
    .o_press_evt (w_press_evt)
  );

  assign w_sen      = r_sen_sync[1];
  assign w_fb       = '{pg_rise: PG & ~r_pg_q, rg_rise: RG & ~r_rg_q};

  // Service completion clears the request and beats a same-cycle press;
  // presses while pedestrians already have green are dropped.
  assign w_button_nxt = w_fb.pg_rise ? 1'b0 :
                        (w_press_evt && !PG) ? 1'b1 : r_button;

  assign BUTTON     = r_button;
  assign SENSOR     = r_sensor;
  assign WAIT_LAMP  = r_wait;
  assign SERVED_CNT = r_served;

  // Synchronize the vehicle loop; keep last PG/RG for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sen_sync <= 2'b00;
      r_pg_q     <= 1'b0;
      r_rg_q     <= 1'b0;
    end else begin
      r_sen_sync <= {r_sen_sync[0], SENSOR_RAW};
      r_pg_q     <= PG;
      r_rg_q     <= RG;
    end
  end

  // Vehicle qualifier: SENSOR_HOLD consecutive high samples raise SENSOR;
  // RG rising restarts qualification so a parked vehicle re-requests later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold   <= '0;
      r_sensor <= 1'b0;
    end else if (!w_sen || w_fb.rg_rise) begin
      r_hold   <= '0;
      r_sensor <= 1'b0;
    end else begin
      if (r_hold != SH_TERM) r_hold <= r_hold + CNT_ONE;
      if (r_hold == SH_TERM) r_sensor <= 1'b1;
    end
  end

  // Pedestrian request latch and its WAIT lamp mirror.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_button <= 1'b0;
      r_wait   <= 1'b0;
    end else begin
      r_button <= w_button_nxt;
      r_wait   <= w_button_nxt;
    end
  end

  // Count only requests that were actually pending when green arrived.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          r_served <= '0;
    else if (w_fb.pg_rise && r_button) r_served <= sat_inc(r_served);
  end

endmodule

// File: tb/tb_crosswalk_request_unit.sv
// Bench for crosswalk_request_unit: directed scenarios plus a randomized phase,
// checked every cycle against a run-length based reference model.
module tb_crosswalk_request_unit;

  localparam int D  = 4;
  localparam int SH = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTN_RAW = 1'b0;
  logic       SENSOR_RAW = 1'b0;
  logic       PG = 1'b0;
  logic       RG = 1'b0;
  logic       BUTTON, SENSOR, WAIT_LAMP;
  logic [7:0] SERVED_CNT;

  int n_vec = 0;
  int n_err = 0;
  int n_evt = 0;

  always #5 CLK = ~CLK;

  crosswalk_request_unit #(
    .DEBOUNCE_CYCLES (D),
    .SENSOR_HOLD     (SH),
    .CNT_W           (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BTN_RAW    (BTN_RAW),
    .SENSOR_RAW (SENSOR_RAW),
    .PG         (PG),
    .RG         (RG),
    .BUTTON     (BUTTON),
    .SENSOR     (SENSOR),
    .WAIT_LAMP  (WAIT_LAMP),
    .SERVED_CNT (SERVED_CNT)
  );

  // Reference model: synchronizer is a 2-sample delay; debounced level flips
  // after D consecutive differing samples; SENSOR = run of high samples since
  // last drop/RG rise has reached SH.
  bit m_b1, m_b2, m_s1, m_s2, m_pgq, m_rgq, m_db, m_evt, m_button, m_sensor;
  bit m_pgr, m_rgr;
  int m_run, m_hold, m_served;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_b1 = 0; m_b2 = 0; m_s1 = 0; m_s2 = 0; m_pgq = 0; m_rgq = 0;
      m_db = 0; m_evt = 0; m_button = 0; m_sensor = 0;
      m_run = 0; m_hold = 0; m_served = 0;
    end else begin
      m_pgr = PG && !m_pgq;
      m_rgr = RG && !m_rgq;
      if (m_pgr && m_button && m_served < 255) m_served++;
      if (m_pgr) m_button = 0;
      else if (m_evt && !PG) m_button = 1;
      if (m_b2 != m_db) begin
        m_run++;
        if (m_run == D) begin
          m_db = m_b2; m_run = 0; m_evt = m_b2;
        end else m_evt = 0;
      end else begin
        m_run = 0; m_evt = 0;
      end
      if (!m_s2 || m_rgr) m_hold = 0;
      else m_hold++;
      m_sensor = (m_hold >= SH);
      m_b2 = m_b1; m_b1 = BTN_RAW;
      m_s2 = m_s1; m_s1 = SENSOR_RAW;
      m_pgq = PG; m_rgq = RG;
    end
  end

  always @(negedge CLK) if (RST === 1'b0 && dut.w_press_evt === 1'b1) n_evt++;

  task automatic check_outputs();
    n_vec++;
    assert (BUTTON === m_button) else begin
      n_err++; $error("FAIL model_button got %b exp %b t=%0t", BUTTON, m_button, $time);
    end
    n_vec++;
    assert (WAIT_LAMP === m_button) else begin
      n_err++; $error("FAIL model_wait got %b exp %b t=%0t", WAIT_LAMP, m_button, $time);
    end
    n_vec++;
    assert (SENSOR === m_sensor) else begin
      n_err++; $error("FAIL model_sensor got %b exp %b t=%0t", SENSOR, m_sensor, $time);
    end
    n_vec++;
    assert (SERVED_CNT === 8'(m_served)) else begin
      n_err++; $error("FAIL model_served got %0d exp %0d t=%0t", SERVED_CNT, m_served, $time);
    end
  endtask

  task automatic expect_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++; $error("FAIL %s got %0d exp %0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    check_outputs();
  endtask

  int ev0;
  int btn_left, sen_left;

  initial begin
    RST = 1'b1;
    step(); step();
    expect_val("rst_button", 16'(BUTTON), 0);
    expect_val("rst_sensor", 16'(SENSOR), 0);
    expect_val("rst_wait", 16'(WAIT_LAMP), 0);
    expect_val("rst_served", 16'(SERVED_CNT), 0);
    RST = 1'b0;

    // Clean press: BUTTON at edge D+3, one event for a long hold.
    BTN_RAW = 1;
    repeat (D + 2) step();
    expect_val("t1_button_early", 16'(BUTTON), 0);
    step();
    expect_val("t1_button_edge7", 16'(BUTTON), 1);
    expect_val("t1_wait_edge7", 16'(WAIT_LAMP), 1);
    repeat (13) step();
    #1 expect_val("t1_one_evt", 16'(n_evt), 1);
    PG = 1; step();
    expect_val("t1_button_cleared", 16'(BUTTON), 0);
    expect_val("t1_served", 16'(SERVED_CNT), 1);
    PG = 0; BTN_RAW = 0;
    repeat (8) step();

    // Bounce every 2 cycles never debounces.
    ev0 = n_evt;
    for (int i = 0; i < 20; i++) begin
      BTN_RAW = ~BTN_RAW;
      repeat (2) step();
    end
    #1 expect_val("t2_no_evt", 16'(n_evt), 16'(ev0));
    expect_val("t2_button", 16'(BUTTON), 0);
    BTN_RAW = 0;
    repeat (8) step();

    // Press during pedestrian green is ignored.
    PG = 1; step();
    BTN_RAW = 1; repeat (10) step();
    expect_val("t3_button_pg", 16'(BUTTON), 0);
    expect_val("t3_served_pg", 16'(SERVED_CNT), 1);
    BTN_RAW = 0; repeat (8) step();
    PG = 0; step();
    BTN_RAW = 1; repeat (D + 3) step();
    expect_val("t3_button_again", 16'(BUTTON), 1);

    // Press event coincident with PG rise: clear wins, count advances.
    BTN_RAW = 0; repeat (8) step();
    BTN_RAW = 1; repeat (D + 2) step();
    expect_val("t4_evt_high", 16'(dut.w_press_evt), 1);
    PG = 1; step();
    expect_val("t4_button_clear", 16'(BUTTON), 0);
    expect_val("t4_served", 16'(SERVED_CNT), 2);
    PG = 0; BTN_RAW = 0; repeat (8) step();

    // Saturation of the served counter.
    for (int i = 0; i < 260; i++) begin
      BTN_RAW = 1; repeat (8) step();
      BTN_RAW = 0; PG = 1; step();
      PG = 0; repeat (7) step();
    end
    expect_val("t4_served_sat", 16'(SERVED_CNT), 255);

    // Sensor: short blip, qualification at edge 5, RG re-qualification.
    SENSOR_RAW = 1; repeat (2) step();
    SENSOR_RAW = 0;
    for (int i = 0; i < 6; i++) begin
      step(); expect_val("t5_short", 16'(SENSOR), 0);
    end
    SENSOR_RAW = 1; repeat (4) step();
    expect_val("t5_early", 16'(SENSOR), 0);
    step();
    expect_val("t5_edge5", 16'(SENSOR), 1);
    RG = 1; step();
    expect_val("t5_rg_clear", 16'(SENSOR), 0);
    RG = 0; step(); step();
    expect_val("t5_requal_early", 16'(SENSOR), 0);
    step();
    expect_val("t5_requal", 16'(SENSOR), 1);

    // Async reset with both requests up, then button re-qualifies.
    BTN_RAW = 1; repeat (D + 3) step();
    expect_val("t6_button_pre", 16'(BUTTON), 1);
    expect_val("t6_sensor_pre", 16'(SENSOR), 1);
    #2 RST = 1;
    #1;
    expect_val("t6_rst_button", 16'(BUTTON), 0);
    expect_val("t6_rst_sensor", 16'(SENSOR), 0);
    expect_val("t6_rst_wait", 16'(WAIT_LAMP), 0);
    expect_val("t6_rst_served", 16'(SERVED_CNT), 0);
    @(negedge CLK);
    RST = 0;
    repeat (D + 2) step();
    expect_val("t6_button_early", 16'(BUTTON), 0);
    step();
    expect_val("t6_button_again", 16'(BUTTON), 1);

    // Randomized traffic against the model.
    btn_left = 0; sen_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (btn_left == 0) begin
        BTN_RAW  = 1'($urandom_range(0, 1));
        btn_left = $urandom_range(1, 12);
      end else btn_left--;
      if (sen_left == 0) begin
        SENSOR_RAW = 1'($urandom_range(0, 1));
        sen_left   = $urandom_range(1, 8);
      end else sen_left--;
      if ($urandom_range(0, 7) == 0) PG = ~PG;
      if ($urandom_range(0, 7) == 0) RG = ~RG;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
